// File: rtl/registro_historial_pkg.sv
// Shared defaults and derived widths for the history register and its users.
package reg_pkg;
    localparam int PROFUNDIDAD_DEF = 32;
    localparam int ANCHO_DEF       = 16;

    // Index width for a given depth; a depth of 1 still needs a 1-bit address.
    function automatic int idx_w(input int prof);
        return (prof > 1) ? $clog2(prof) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_w(PROFUNDIDAD_DEF);
    localparam int CNT_W_DEF = IDX_W_DEF + 1;
endpackage

// File: rtl/registro_historial_if.sv
// Bus bundle between a history-register client (master) and registro_historial (slave).
interface registro_historial_if
    import reg_pkg::*;
#(
    parameter int PROFUNDIDAD = PROFUNDIDAD_DEF,
    parameter int ANCHO       = ANCHO_DEF
);
    localparam int IW = idx_w(PROFUNDIDAD);
    localparam int CW = IW + 1;

    // Strobe semantics: REGiniciar/leer_ahora are sampled on every rising edge
    // they are high; there is no ready/backpressure. valor_leer_listo is a
    // one-cycle valid pulse for leer_data, exactly two cycles after leer_ahora.
    logic             REGiniciar;
    logic [ANCHO-1:0] nuevo_dato;
    logic             borrar;
    logic             leer_ahora;
    logic [IW-1:0]    leer_index;
    logic [ANCHO-1:0] leer_data;
    logic             valor_leer_listo;
    logic [IW-1:0]    REGposicion;
    logic [CW-1:0]    REGContador;
    logic             REGlleno;
    logic             REGdesborde;

    modport master (
        output REGiniciar, nuevo_dato, borrar, leer_ahora, leer_index,
        input  leer_data, valor_leer_listo, REGposicion, REGContador, REGlleno, REGdesborde
    );

    modport slave (
        input  REGiniciar, nuevo_dato, borrar, leer_ahora, leer_index,
        output leer_data, valor_leer_listo, REGposicion, REGContador, REGlleno, REGdesborde
    );
endinterface

// File: rtl/registro_historial_ram.sv
// Simple dual-port storage: one synchronous write, one synchronous read, no reset.
module ram_historial
    import reg_pkg::*;
#(
    parameter int DEPTH = PROFUNDIDAD_DEF,
    parameter int WIDTH = ANCHO_DEF,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Nonblocking read and write on the same edge gives read-before-write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/registro_historial.sv
// Circular history of the last PROFUNDIDAD words with random-access, two-cycle reads.
module registro_historial
    import reg_pkg::*;
#(
    parameter int PROFUNDIDAD = PROFUNDIDAD_DEF,
    parameter int ANCHO       = ANCHO_DEF
) (
    input  logic                clk,
    input  logic                reset,
    registro_historial_if.slave bus
);
    localparam int IW = idx_w(PROFUNDIDAD);
    localparam int CW = IW + 1;

    logic [IW-1:0]          r_pos;
    logic [CW-1:0]          r_cnt;
    logic                   r_desborde;
    logic [PROFUNDIDAD-1:0] r_vld;
    logic                   r_rd_v1;
    logic                   r_rd_bit;
    logic                   r_listo;
    logic [ANCHO-1:0]       r_data;

    logic                   w_wr_en;
    logic                   w_lleno;
    logic [ANCHO-1:0]       w_ram_q;

    assign w_wr_en = bus.REGiniciar & ~bus.borrar;
    assign w_lleno = (r_cnt == CW'(PROFUNDIDAD));

    // Stage 1 of the read is the RAM's own output register, so the word is
    // fetched on the same edge that samples the request (pre-write content).
    ram_historial #(
        .DEPTH (PROFUNDIDAD),
        .WIDTH (ANCHO),
        .AW    (IW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_pos),
        .i_wdata (bus.nuevo_dato),
        .i_raddr (bus.leer_index),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos      <= '0;
            r_cnt      <= '0;
            r_desborde <= 1'b0;
            r_vld      <= '0;
            r_rd_v1    <= 1'b0;
            r_rd_bit   <= 1'b0;
            r_listo    <= 1'b0;
            r_data     <= '0;
        end else if (bus.borrar) begin
            // Clear drops the same-cycle write and squashes every in-flight read.
            r_pos      <= '0;
            r_cnt      <= '0;
            r_desborde <= 1'b0;
            r_vld      <= '0;
            r_rd_v1    <= 1'b0;
            r_listo    <= 1'b0;
        end else begin
            if (bus.REGiniciar) begin
                r_vld[r_pos] <= 1'b1;
                r_pos        <= r_pos + IW'(1);
                if (w_lleno) begin
                    r_desborde <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            r_rd_v1  <= bus.leer_ahora;
            r_rd_bit <= r_vld[bus.leer_index];
            r_listo  <= r_rd_v1;
            if (r_rd_v1) begin
                r_data <= r_rd_bit ? w_ram_q : '0;
            end
        end
    end

    assign bus.leer_data        = r_data;
    assign bus.valor_leer_listo = r_listo;
    assign bus.REGposicion      = r_pos;
    assign bus.REGContador      = r_cnt;
    assign bus.REGlleno         = w_lleno;
    assign bus.REGdesborde      = r_desborde;
endmodule

// File: doc/registro_historial.md
REGISTRO_HISTORIAL -- requirements
Module: registro_historial

Interface
REQ-001 Parameter PROFUNDIDAD, default 32, number of stored words; power of two.
REQ-002 Parameter ANCHO, default 16, bits per stored word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 REGiniciar  input  1  write strobe; one word is written per cycle in which it is high.
REQ-006 nuevo_dato  input  ANCHO  write data, sampled when REGiniciar=1.
REQ-007 borrar  input  1  synchronous clear of the history pointers.
REQ-008 leer_ahora  input  1  read request strobe.
REQ-009 leer_index  input  log2(PROFUNDIDAD)  absolute slot address, sampled when leer_ahora=1.
REQ-010 leer_data  output  ANCHO  read response data.
REQ-011 valor_leer_listo  output  1  one-cycle pulse qualifying leer_data.
REQ-012 REGposicion  output  log2(PROFUNDIDAD)  next slot to be written.
REQ-013 REGContador  output  log2(PROFUNDIDAD)+1  valid-word count, 0..PROFUNDIDAD.
REQ-014 REGlleno  output  1  high while REGContador==PROFUNDIDAD.
REQ-015 REGdesborde  output  1  sticky flag: a write occurred while full (oldest word overwritten).

Function
REQ-016 Each write stores nuevo_dato at slot REGposicion, then REGposicion increments modulo PROFUNDIDAD (31 -> 0).
REQ-017 REGContador increments on each write and saturates at PROFUNDIDAD; the oldest valid word is always at slot (REGposicion - REGContador) mod PROFUNDIDAD.
REQ-018 A write while REGlleno=1 overwrites the oldest word, leaves REGContador at PROFUNDIDAD and sets REGdesborde.
REQ-019 REGposicion, REGContador and REGlleno update on the same edge that samples the write; their new values are visible one cycle after REGiniciar.
REQ-020 Read pipeline has two stages: edge N samples leer_ahora/leer_index; edge N+1 registers the memory word; valor_leer_listo=1 and leer_data are valid during the cycle after edge N+1, i.e. fixed latency 2 cycles.
REQ-021 Back-to-back reads are accepted every cycle; responses return in request order with no bubbles; no busy/backpressure exists.
REQ-022 leer_data holds its last response value between pulses.
REQ-023 A read of any index returns stored memory content irrespective of REGContador; invalid slots return 0 after reset or borrar.
REQ-024 Write and read of the same slot in the same cycle: read returns the pre-write value (read-before-write).
REQ-025 borrar=1: REGposicion, REGContador and REGdesborde go to 0 and all slots read as 0 from the next cycle; in-flight reads are discarded (no valor_leer_listo).
REQ-026 borrar and REGiniciar in the same cycle: borrar wins, the write is dropped.
REQ-027 A valid-slot bitmap of PROFUNDIDAD bits implements REQ-023/025: set on write, all cleared on borrar; read data is masked to 0 when the bit is clear.

Reset
REQ-028 While reset=0: REGposicion=0, REGContador=0, REGlleno=0, REGdesborde=0, valor_leer_listo=0, leer_data=0, valid bitmap all 0, read pipeline empty.
REQ-029 Reset asserted mid-read discards all pending responses; memory array contents need not be cleared (masked by the bitmap).
REQ-030 Deassertion is taken synchronously; the first write may occur on the first edge after release.

Structure
REQ-031 Shared package reg_pkg holds PROFUNDIDAD/ANCHO defaults and the derived index and count widths used by this block and by Control.
REQ-032 Storage is a sub-module ram_historial: one synchronous write port, one synchronous read port, no reset, inferable as distributed/block RAM.
REQ-033 Pointer, counter, bitmap and read pipeline live in registro_historial.

Verification
REQ-034 Write 0x0011, 0x0022, 0x0033 on consecutive cycles -> REGposicion=3, REGContador=3; read index 1 -> valor_leer_listo exactly 2 cycles later with leer_data=0x0022.
REQ-035 Write 33 words 0..32 -> REGContador=32, REGlleno=1, REGdesborde=1, REGposicion=1; read index 0 returns 32, oldest slot (1-32 mod 32)=1 returns 1.
REQ-036 Reads of indices 0,1,2 on three consecutive cycles -> three consecutive valor_leer_listo pulses with data in order.
REQ-037 Write 0xAAAA to slot 5 and read index 5 in the same cycle, previous content 0x1234 -> leer_data=0x1234; next read of 5 returns 0xAAAA.
REQ-038 borrar with REGiniciar and a read in flight -> count 0, position 0, no response pulse, subsequent read of any index returns 0.
REQ-039 Drive reset=0 one cycle after leer_ahora -> no valor_leer_listo, all outputs 0 during reset.
